// File: rtl/timer_pkg.sv
// Shared register map constants and FSM state types for the timer channel controller.
package timer_pkg;

   // Word index within a channel's 16-byte block (byte offsets 0x0, 0x4, 0x8, 0xC).
   localparam logic [1:0] RegCtrl  = 2'd0;
   localparam logic [1:0] RegTerm  = 2'd1;
   localparam logic [1:0] RegCount = 2'd2;
   localparam logic [1:0] RegStat  = 2'd3;

   localparam int unsigned CtrlStartBit = 0;
   localparam int unsigned CtrlHaltBit  = 1;
   localparam int unsigned CtrlModeBit  = 2;
   localparam int unsigned CtrlIeBit    = 3;

   localparam int unsigned StatRunBit  = 0;
   localparam int unsigned StatPendBit = 1;

   typedef enum logic [1:0] {
      SeqIdle,
      SeqHaltHi,
      SeqGap,
      SeqStartHi
   } seq_state_e;

   typedef enum logic {
      SchArb,
      SchPresent
   } sch_state_e;

endpackage

// File: rtl/timer_irq_arb.sv
// Sticky pending bits per channel and a round-robin presenter driving one CPU interrupt line
// with an ID and an acknowledge handshake.
module timer_irq_arb
   import timer_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned IDW = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [NCH-1:0] int_set,
   input  logic [NCH-1:0] w1c_clr,
   input  logic [NCH-1:0] ie,
   input  logic           irq_ack,
   output logic [NCH-1:0] pend,
   output logic           irq,
   output logic [IDW-1:0] irq_id
);

   sch_state_e     state_q;
   logic [NCH-1:0] pend_q, pend_d;
   logic [NCH-1:0] id_hot, ack_clr, eff;
   logic [IDW-1:0] last_q, grant;
   logic           grant_vld, keep;

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         id_hot[c] = (irq_id == IDW'(c));
      end
      ack_clr = id_hot & {NCH{(state_q == SchPresent) && irq_ack}};
      // A new interrupt pulse outranks any clear landing in the same cycle.
      pend_d  = (pend_q & ~(w1c_clr | ack_clr)) | int_set;
      eff     = pend_q & ie;
      keep    = |(pend_d & ie & id_hot);

      grant     = last_q;
      grant_vld = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         for (int c = 0; c < NCH; c++) begin
            if (!grant_vld && eff[c] && (c == (int'(last_q) + i) % NCH)) begin
               grant_vld = 1'b1;
               grant     = IDW'(c);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SchArb;
         pend_q  <= '0;
         last_q  <= IDW'(NCH - 1);
         irq     <= 1'b0;
         irq_id  <= '0;
      end else begin
         pend_q <= pend_d;
         case (state_q)
            SchArb: begin
               if (grant_vld) begin
                  irq_id  <= grant;
                  irq     <= 1'b1;
                  state_q <= SchPresent;
               end
            end
            SchPresent: begin
               if (irq_ack) begin
                  last_q  <= irq_id;
                  irq     <= 1'b0;
                  state_q <= SchArb;
               end else if (!keep) begin
                  // Withdrawn by W1C or mask: re-arbitrate without advancing the pointer.
                  irq     <= 1'b0;
                  state_q <= SchArb;
               end
            end
            default: state_q <= SchArb;
         endcase
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/timer_ctrl.sv
// Bus-mapped controller for NCH timing channels: config registers, trigger sequencers and IRQ.
// Optional per-channel interrupt enable via TIMER_CTRL_IRQ_MASK_EN.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              bus_sel,
   input  logic              bus_we,
   input  logic [IDW+3:0]    bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic              bus_ready,
   output logic [NCH-1:0]    ro_trig_start,
   output logic [NCH-1:0]    ro_trig_halt,
   output logic [NCH-1:0]    ro_mode,
   output logic [NCH*32-1:0] ro_termcount,
   input  logic [NCH-1:0]    rf_status,
   input  logic [NCH*32-1:0] rf_currcount,
   input  logic [NCH-1:0]    rf_int,
   output logic              irq,
   output logic [IDW-1:0]    irq_id,
   input  logic              irq_ack
);

   logic [IDW-1:0]    ch_idx;
   logic [1:0]        reg_sel;
   logic              wr_en, rd_en, unused_addr;
   logic [NCH-1:0]    ch_hit, ctrl_wr, term_wr, w1c_clr;
   logic [NCH-1:0]    mode_q, restart_q, ie, ie_rd, pend;
   logic [NCH*32-1:0] term_q;
   logic [31:0]       rdata_d;
   seq_state_e        seq_q [NCH];

   assign ch_idx      = bus_addr[IDW+3:4];
   assign reg_sel     = bus_addr[3:2];
   assign wr_en       = bus_sel & bus_we;
   assign rd_en       = bus_sel & ~bus_we;
   assign unused_addr = ^bus_addr[1:0];

   // Channel indices at or beyond NCH never hit, so their writes drop and reads return 0.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         ch_hit[c]  = (ch_idx == IDW'(c));
         ctrl_wr[c] = wr_en && ch_hit[c] && (reg_sel == RegCtrl);
         term_wr[c] = wr_en && ch_hit[c] && (reg_sel == RegTerm);
         w1c_clr[c] = wr_en && ch_hit[c] && (reg_sel == RegStat) && bus_wdata[StatPendBit];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q <= '0;
         term_q <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (ctrl_wr[c]) mode_q[c] <= bus_wdata[CtrlModeBit];
            if (term_wr[c]) term_q[32*c +: 32] <= bus_wdata;
         end
      end
   end

`ifdef TIMER_CTRL_IRQ_MASK_EN
   logic [NCH-1:0] ie_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ie_q <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (ctrl_wr[c]) ie_q[c] <= bus_wdata[CtrlIeBit];
         end
      end
   end

   assign ie    = ie_q;
   assign ie_rd = ie_q;
`else
   assign ie    = '1;
   assign ie_rd = '0;
`endif

   // Trigger sequencers; a restart routes through the gap so halt always precedes start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NCH; c++) seq_q[c] <= SeqIdle;
         restart_q     <= '0;
         ro_trig_start <= '0;
         ro_trig_halt  <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            case (seq_q[c])
               SeqIdle: begin
                  if (ctrl_wr[c] && bus_wdata[CtrlHaltBit]) begin
                     seq_q[c]        <= SeqHaltHi;
                     restart_q[c]    <= bus_wdata[CtrlStartBit];
                     ro_trig_halt[c] <= 1'b1;
                  end else if (ctrl_wr[c] && bus_wdata[CtrlStartBit]) begin
                     seq_q[c]         <= SeqStartHi;
                     ro_trig_start[c] <= 1'b1;
                  end
               end
               SeqHaltHi: begin
                  ro_trig_halt[c] <= 1'b0;
                  seq_q[c]        <= restart_q[c] ? SeqGap : SeqIdle;
               end
               SeqGap: begin
                  restart_q[c]     <= 1'b0;
                  ro_trig_start[c] <= 1'b1;
                  seq_q[c]         <= SeqStartHi;
               end
               SeqStartHi: begin
                  ro_trig_start[c] <= 1'b0;
                  seq_q[c]         <= SeqIdle;
               end
               default: seq_q[c] <= SeqIdle;
            endcase
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      for (int c = 0; c < NCH; c++) begin
         if (rd_en && ch_hit[c]) begin
            case (reg_sel)
               RegCtrl: begin
                  rdata_d[CtrlModeBit] = mode_q[c];
                  rdata_d[CtrlIeBit]   = ie_rd[c];
               end
               RegTerm:  rdata_d = term_q[32*c +: 32];
               RegCount: rdata_d = rf_currcount[32*c +: 32];
               RegStat: begin
                  rdata_d[StatRunBit]  = rf_status[c];
                  rdata_d[StatPendBit] = pend[c];
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_ready <= 1'b0;
         bus_rdata <= '0;
      end else begin
         bus_ready <= bus_sel;
         bus_rdata <= rdata_d;
      end
   end

   assign ro_mode      = mode_q;
   assign ro_termcount = term_q;

   timer_irq_arb #(
      .NCH (NCH),
      .IDW (IDW)
   ) u_irq_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .int_set (rf_int),
      .w1c_clr (w1c_clr),
      .ie      (ie),
      .irq_ack (irq_ack),
      .pend    (pend),
      .irq     (irq),
      .irq_id  (irq_id)
   );

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with NCH=4; also exercises TIMER_CTRL_IRQ_MASK_EN when defined.
module tb_timer_ctrl;

   localparam int RCTRL = 0;
   localparam int RTERM = 1;
   localparam int RCOUNT = 2;
   localparam int RSTAT = 3;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         bus_sel = 1'b0, bus_we = 1'b0;
   logic [5:0]   bus_addr = '0;
   logic [31:0]  bus_wdata = '0;
   logic [31:0]  bus_rdata;
   logic         bus_ready;
   logic [3:0]   ro_trig_start, ro_trig_halt, ro_mode;
   logic [127:0] ro_termcount;
   logic [3:0]   rf_status = '0;
   logic [127:0] rf_currcount = '0;
   logic [3:0]   rf_int = '0;
   logic         irq;
   logic [1:0]   irq_id;
   logic         irq_ack = 1'b0;

   int errors = 0;
   int checks = 0;

   timer_ctrl #(
      .NCH (4),
      .IDW (2)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus_sel       (bus_sel),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_ready     (bus_ready),
      .ro_trig_start (ro_trig_start),
      .ro_trig_halt  (ro_trig_halt),
      .ro_mode       (ro_mode),
      .ro_termcount  (ro_termcount),
      .rf_status     (rf_status),
      .rf_currcount  (rf_currcount),
      .rf_int        (rf_int),
      .irq           (irq),
      .irq_id        (irq_id),
      .irq_ack       (irq_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input int ch, input int r, input logic [31:0] d);
      bus_sel   = 1'b1;
      bus_we    = 1'b1;
      bus_addr  = 6'(ch * 16 + r * 4);
      bus_wdata = d;
      tick();
      bus_sel   = 1'b0;
      bus_we    = 1'b0;
   endtask

   task automatic bus_read(input int ch, input int r, output logic [31:0] d, output logic rdy);
      bus_sel  = 1'b1;
      bus_we   = 1'b0;
      bus_addr = 6'(ch * 16 + r * 4);
      tick();
      d        = bus_rdata;
      rdy      = bus_ready;
      bus_sel  = 1'b0;
   endtask

   task automatic pulse_int(input logic [3:0] v);
      rf_int = v;
      tick();
      rf_int = '0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic enable_all_ie();
`ifdef TIMER_CTRL_IRQ_MASK_EN
      for (int c = 0; c < 4; c++) bus_write(c, RCTRL, 32'h8);
`endif
   endtask

   task automatic test_reset();
      logic [175:0] outs;
      tick();
      outs = {ro_trig_start, ro_trig_halt, ro_mode, ro_termcount, bus_rdata, bus_ready, irq, irq_id};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0", outs);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_start();
      logic [31:0] d;
      logic        rdy;
      bus_write(0, RTERM, 32'd5);
      checks++;
      if (ro_termcount[31:0] !== 32'd5) begin
         errors++;
         $display("FAIL term0: got %0d required 5", ro_termcount[31:0]);
      end
      bus_write(0, RCTRL, 32'h1);
      checks++;
      if (ro_trig_start !== 4'b0001 || ro_trig_halt !== 4'b0000) begin
         errors++;
         $display("FAIL start_t1: got start=%b halt=%b required 0001/0000", ro_trig_start,
                  ro_trig_halt);
      end
      tick();
      checks++;
      if (ro_trig_start !== 4'b0000) begin
         errors++;
         $display("FAIL start_t2: got %b required 0000", ro_trig_start);
      end
      bus_read(0, RTERM, d, rdy);
      checks++;
      if (d !== 32'd5 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL read_term0: got %h ready=%b required 5 ready=1", d, rdy);
      end
      bus_read(0, RCTRL, d, rdy);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL read_ctrl0_start: got %h required 0", d);
      end
      bus_write(0, RCTRL, 32'h4);
      checks++;
      if (ro_mode !== 4'b0001 || ro_trig_start !== 4'b0000) begin
         errors++;
         $display("FAIL mode0: got mode=%b start=%b required 0001/0000", ro_mode, ro_trig_start);
      end
      bus_read(0, RCTRL, d, rdy);
      checks++;
      if (d !== 32'h4) begin
         errors++;
         $display("FAIL read_ctrl0_mode: got %h required 4", d);
      end
   endtask

   task automatic test_restart();
      bus_write(1, RCTRL, 32'h3);
      checks++;
      if (ro_trig_halt !== 4'b0010 || ro_trig_start !== 4'b0000) begin
         errors++;
         $display("FAIL restart_t1: got halt=%b start=%b required 0010/0000", ro_trig_halt,
                  ro_trig_start);
      end
      // Second write lands while the sequencer is busy: triggers ignored, MODE still taken.
      bus_write(1, RCTRL, 32'h5);
      checks++;
      if (ro_trig_halt !== 4'b0000 || ro_trig_start !== 4'b0000 || ro_mode !== 4'b0011) begin
         errors++;
         $display("FAIL restart_t2: got halt=%b start=%b mode=%b required 0000/0000/0011",
                  ro_trig_halt, ro_trig_start, ro_mode);
      end
      tick();
      checks++;
      if (ro_trig_start !== 4'b0010 || ro_trig_halt !== 4'b0000) begin
         errors++;
         $display("FAIL restart_t3: got start=%b halt=%b required 0010/0000", ro_trig_start,
                  ro_trig_halt);
      end
      tick();
      tick();
      checks++;
      if (ro_trig_start !== 4'b0000 || ro_trig_halt !== 4'b0000) begin
         errors++;
         $display("FAIL restart_t5: got start=%b halt=%b required 0000/0000", ro_trig_start,
                  ro_trig_halt);
      end
      bus_write(2, RCTRL, 32'h2);
      checks++;
      if (ro_trig_halt !== 4'b0100) begin
         errors++;
         $display("FAIL halt_only_t1: got %b required 0100", ro_trig_halt);
      end
      tick();
      tick();
      checks++;
      if (ro_trig_start !== 4'b0000 || ro_trig_halt !== 4'b0000) begin
         errors++;
         $display("FAIL halt_only_t3: got start=%b halt=%b required 0000/0000", ro_trig_start,
                  ro_trig_halt);
      end
   endtask

   task automatic test_count_stat();
      logic [31:0] d;
      logic        rdy;
      rf_currcount[127:96] = 32'hDEADBEEF;
      rf_status = 4'b1000;
      bus_read(3, RCOUNT, d, rdy);
      checks++;
      if (d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_count3: got %h required deadbeef", d);
      end
      bus_read(3, RSTAT, d, rdy);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL read_stat3: got %h required 1", d);
      end
   endtask

   task automatic test_irq_rr();
      logic [31:0] d;
      logic        rdy;
      enable_all_ie();
      pulse_int(4'b1011);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_early: got %b required 0", irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd0) begin
         errors++;
         $display("FAIL rr_first: got irq=%b id=%0d required 1/0", irq, irq_id);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd0) begin
         errors++;
         $display("FAIL rr_hold: got irq=%b id=%0d required 1/0", irq, irq_id);
      end
      ack();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL rr_gap1: got %b required 0", irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd1) begin
         errors++;
         $display("FAIL rr_second: got irq=%b id=%0d required 1/1", irq, irq_id);
      end
      ack();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL rr_gap2: got %b required 0", irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd3) begin
         errors++;
         $display("FAIL rr_third: got irq=%b id=%0d required 1/3", irq, irq_id);
      end
      ack();
      tick();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL rr_drained: got %b required 0", irq);
      end
      bus_read(3, RSTAT, d, rdy);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL stat3_acked: got %h required 1", d);
      end
   endtask

   task automatic test_w1c();
      logic [31:0] d;
      logic        rdy;
      pulse_int(4'b0100);
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd2) begin
         errors++;
         $display("FAIL w1c_present: got irq=%b id=%0d required 1/2", irq, irq_id);
      end
      bus_write(2, RSTAT, 32'h2);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_drop: got %b required 0", irq);
      end
      tick();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_stay_low: got %b required 0", irq);
      end
      pulse_int(4'b0100);
      tick();
      rf_int  = 4'b0100;
      irq_ack = 1'b1;
      tick();
      rf_int  = '0;
      irq_ack = 1'b0;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL set_ack_drop: got %b required 0", irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd2) begin
         errors++;
         $display("FAIL set_wins: got irq=%b id=%0d required 1/2", irq, irq_id);
      end
      bus_read(2, RSTAT, d, rdy);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL stat2_pend: got %h required 2", d);
      end
      ack();
      bus_read(2, RSTAT, d, rdy);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL stat2_cleared: got %h required 0", d);
      end
      // An ack while nothing is presented must not swallow the freshly latched pend.
      pulse_int(4'b0010);
      ack();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd1) begin
         errors++;
         $display("FAIL ack_in_arb: got irq=%b id=%0d required 1/1", irq, irq_id);
      end
      ack();
   endtask

   task automatic test_mask();
      logic [31:0] d;
      logic        rdy;
`ifdef TIMER_CTRL_IRQ_MASK_EN
      bus_write(0, RCTRL, 32'h0);
      pulse_int(4'b0001);
      tick();
      tick();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL masked_irq: got %b required 0", irq);
      end
      bus_read(0, RSTAT, d, rdy);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL masked_stat0: got %h required 2", d);
      end
      bus_write(0, RCTRL, 32'h8);
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd0) begin
         errors++;
         $display("FAIL unmasked_irq: got irq=%b id=%0d required 1/0", irq, irq_id);
      end
      ack();
      bus_read(0, RCTRL, d, rdy);
      checks++;
      if (d !== 32'h8) begin
         errors++;
         $display("FAIL ie_read: got %h required 8", d);
      end
`else
      bus_write(0, RCTRL, 32'h8);
      bus_read(0, RCTRL, d, rdy);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL ie_absent_read: got %h required 0", d);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [175:0] outs;
      pulse_int(4'b1100);
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd2) begin
         errors++;
         $display("FAIL pre_reset_present: got irq=%b id=%0d required 1/2", irq, irq_id);
      end
      bus_write(0, RCTRL, 32'h1);
      checks++;
      if (ro_trig_start !== 4'b0001) begin
         errors++;
         $display("FAIL pre_reset_start: got %b required 0001", ro_trig_start);
      end
      reset_n = 1'b0;
      #1;
      outs = {ro_trig_start, ro_trig_halt, ro_mode, ro_termcount, bus_rdata, bus_ready, irq, irq_id};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h required 0", outs);
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (ro_trig_start !== 4'b0000 || irq !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got start=%b irq=%b required 0000/0", ro_trig_start, irq);
      end
      enable_all_ie();
      pulse_int(4'b0101);
      tick();
      checks++;
      if (irq !== 1'b1 || irq_id !== 2'd0) begin
         errors++;
         $display("FAIL post_reset_first: got irq=%b id=%0d required 1/0", irq, irq_id);
      end
      bus_write(0, RCTRL, 32'h1);
      checks++;
      if (ro_trig_start !== 4'b0001) begin
         errors++;
         $display("FAIL post_reset_start: got %b required 0001", ro_trig_start);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_restart();
      test_count_stat();
      test_irq_rr();
      test_w1c();
      test_mask();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
